// File: rtl/tmv_majority_voter.sv
// Temporal majority voter for PUF responses.
// Collects VOTES successive WIDTH-bit samples, counts ones per bit, then
// registers the per-bit majority and a per-bit "not unanimous" flag.
// done, vote_out and unstable all update on the edge that closes RESOLVE,
// so a vote aborted in RESOLVE never disturbs the previous result.
module tmv_majority_voter #(
    parameter int WIDTH = 8,
    parameter int VOTES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_in,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] vote_out,
    output logic [WIDTH-1:0] unstable
);

    localparam int CNT_W = $clog2(VOTES + 1);

    // An odd vote count guarantees there is never a tie.
    if ((VOTES < 3) || (VOTES > 255) || (VOTES % 2 == 0) || (WIDTH < 1)) begin : g_param_check
        $error("tmv_majority_voter: VOTES must be odd in 3..255 and WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0][CNT_W-1:0] ones_q, ones_d;
    logic                        resp_ready_q, resp_ready_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [WIDTH-1:0]            vote_out_q, vote_out_d;
    logic [WIDTH-1:0]            unstable_q, unstable_d;
    logic                        accept;

    // Next-state, counter and result computation; outputs are derived from
    // the next state so they are registered alongside it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        done_d     = 1'b0;
        vote_out_d = vote_out_q;
        unstable_d = unstable_q;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    ones_d  = '0;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (resp_valid && resp_ready_q) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    for (int b = 0; b < WIDTH; b++) begin
                        ones_d[b] = ones_q[b] + CNT_W'(resp_in[b]);
                    end
                    if (cnt_q == CNT_W'(VOTES - 1)) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    for (int b = 0; b < WIDTH; b++) begin
                        vote_out_d[b] = (ones_q[b] > CNT_W'(VOTES / 2));
                        unstable_d[b] = (ones_q[b] != '0) && (ones_q[b] != CNT_W'(VOTES));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_ready_d = (state_d == ST_COLLECT) && !(accept && (state_d != ST_COLLECT));
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ones_q       <= '0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vote_out_q   <= '0;
            unstable_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ones_q       <= ones_d;
            resp_ready_q <= resp_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vote_out_q   <= vote_out_d;
            unstable_q   <= unstable_d;
        end
    end

    assign resp_ready = resp_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign vote_out   = vote_out_q;
    assign unstable   = unstable_q;

endmodule
